// File: rtl/vector_sum_acc_pkg.sv
// Shared types and default widths for the vector position-sum accumulator.
// The FSM only ever holds an open frame (ACCUM) or a finished result (HOLD).
package vector_sum_acc_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_POS_W     = 18;
    localparam int DEF_ACC_W     = 24;
    localparam int DEF_FRAME_LEN = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/vector_sum.sv
// Combinational position sum: adds the index of every set bit of one word.
// For a 32-bit all-ones word the result is 0+1+...+31 = 496.
module vector_sum
    import vector_sum_acc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int POS_W  = DEF_POS_W
) (
    input  logic [DATA_W-1:0] data,
    output logic [POS_W-1:0]  sum
);

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path through the block can infer a latch.
    always_comb begin
        sum = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) begin
                sum = sum + POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/vector_sum_acc.sv
// Accumulates per-word position sums over a frame of up to FRAME_LEN words and
// holds the saturated total, word count and overflow flag until it is taken.
module vector_sum_acc
    import vector_sum_acc_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int POS_W     = DEF_POS_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           in_valid,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic [ACC_W-1:0]               out_sum,
    output logic [$clog2(FRAME_LEN+1)-1:0] out_count,
    output logic                           out_ovf,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    // One spare bit above the wider operand so a carry past ACC_W is visible.
    localparam int SUM_W = ((ACC_W > POS_W) ? ACC_W : POS_W) + 1;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic [POS_W-1:0] word_sum;
    logic [SUM_W-1:0] sum_wide;
    logic [CNT_W-1:0] count_inc;
    logic             sat;
    logic             accept;
    logic             close_frame;
    logic             release_res;

    vector_sum #(
        .DATA_W (DATA_W),
        .POS_W  (POS_W)
    ) u_vector_sum (
        .data (in_data),
        .sum  (word_sum)
    );

    assign sum_wide  = SUM_W'(acc) + SUM_W'(word_sum);
    assign sat       = |sum_wide[SUM_W-1:ACC_W];
    assign count_inc = count + CNT_W'(1);

    // Handshakes decoded from the state register, not from in_ready/out_valid,
    // so the output decode below has no feedback through its own outputs.
    assign accept      = in_valid && (state == ACCUM);
    assign release_res = out_ready && (state == HOLD);
    assign close_frame = accept && (in_last || (count_inc == CNT_W'(FRAME_LEN)));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (close_frame) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (release_res) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values; reset is synchronous, checked only on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (release_res) begin
                acc   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end else if (accept) begin
                acc   <= sat ? '1 : sum_wide[ACC_W-1:0];
                ovf   <= ovf | sat;
                count <= count_inc;
            end
        end
    end

    assign out_sum   = out_valid ? acc   : '0;
    assign out_count = out_valid ? count : '0;
    assign out_ovf   = out_valid & ovf;

endmodule

// File: tb/tb_vector_sum_acc.sv
// Bench for vector_sum_acc: two instances (default and ACC_W=12/FRAME_LEN=16)
// share one stimulus stream; a frame-level model is compared every cycle.
module tb_vector_sum_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [23:0] out_sum_a;
    logic [3:0]  out_count_a;
    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [11:0] out_sum_b;
    logic [4:0]  out_count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vector_sum_acc dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready_a), .out_sum(out_sum_a),
        .out_count(out_count_a), .out_ovf(out_ovf_a), .out_valid(out_valid_a),
        .out_ready(out_ready)
    );

    vector_sum_acc #(.DATA_W(32), .POS_W(12), .ACC_W(12), .FRAME_LEN(16)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready_b), .out_sum(out_sum_b),
        .out_count(out_count_b), .out_ovf(out_ovf_b), .out_valid(out_valid_b),
        .out_ready(out_ready)
    );

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic longint word_sum(input logic [31:0] d);
        longint s = 0;
        for (int i = 0; i < 32; i++) if (d[i]) s += i;
        return s;
    endfunction

    // Frame-level model: an open frame is a running total and word count; a
    // closed frame is a clamped total waiting for the consumer.
    typedef struct {
        bit     hold;
        longint total;
        int     cnt;
        longint res_sum;
        int     res_cnt;
        bit     res_ovf;
    } mdl_t;

    function automatic mdl_t mdl_step(input mdl_t m, input bit r, input bit v, input bit l,
                                      input logic [31:0] d, input bit ordy,
                                      input int flen, input int accw);
        mdl_t   n    = m;
        longint maxv = (longint'(1) << accw) - 1;
        if (r) begin
            n = '{default: 0};
        end else if (m.hold) begin
            if (ordy) n.hold = 1'b0;
        end else if (v) begin
            n.total = m.total + word_sum(d);
            n.cnt   = m.cnt + 1;
            if (l || n.cnt == flen) begin
                n.hold    = 1'b1;
                n.res_sum = (n.total > maxv) ? maxv : n.total;
                n.res_ovf = (n.total > maxv);
                n.res_cnt = n.cnt;
                n.total   = 0;
                n.cnt     = 0;
            end
        end
        return n;
    endfunction

    mdl_t m_a = '{default: 0};
    mdl_t m_b = '{default: 0};

    task automatic cmp_dut(input string tag, input mdl_t m, input logic rdy, input logic vld,
                           input longint sum, input longint cnt, input logic ovf);
        check($sformatf("%s.in_ready", tag),  rdy, !m.hold);
        check($sformatf("%s.out_valid", tag), vld, m.hold);
        check($sformatf("%s.out_sum", tag),   sum, m.hold ? m.res_sum : 0);
        check($sformatf("%s.out_count", tag), cnt, m.hold ? m.res_cnt : 0);
        check($sformatf("%s.out_ovf", tag),   ovf, m.hold ? m.res_ovf : 0);
    endtask

    // Back-to-back scoreboard state
    bit     b2b_mon   = 1'b0;
    int     hs_cnt    = 0;
    int     idle_cnt  = 0;
    longint hs_words  = 0;
    longint hs_sum    = 0;

    always @(posedge clk) begin
        m_a = mdl_step(m_a, rst, in_valid, in_last, in_data, out_ready, 8, 24);
        m_b = mdl_step(m_b, rst, in_valid, in_last, in_data, out_ready, 16, 12);
        #1;
        cmp_dut("a", m_a, in_ready_a, out_valid_a, longint'(out_sum_a), longint'(out_count_a), out_ovf_a);
        cmp_dut("b", m_b, in_ready_b, out_valid_b, longint'(out_sum_b), longint'(out_count_b), out_ovf_b);
        if (b2b_mon) begin
            if (out_valid_a && out_ready) begin
                hs_cnt++;
                hs_words += longint'(out_count_a);
                hs_sum   += longint'(out_sum_a);
            end
            if (!in_ready_a) idle_cnt++;
        end
    end

    // Called at a falling edge; returns at the falling edge after the word was
    // offered to the rising edge (and, with wait_rdy, accepted by dut_a).
    task automatic send(input logic [31:0] d, input logic l, input bit wait_rdy);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        if (wait_rdy) begin
            while (!in_ready_a && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed %0d, expected 1", in_ready_a);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint exp_sum;
        rst = 1'b1;
        idle();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_in_ready",  in_ready_a, 1);
        check("reset_out_valid", out_valid_a, 0);
        check("reset_out_sum",   out_sum_a, 0);
        rst = 1'b0;

        // Full frame of all-ones words, closed by FRAME_LEN
        for (int k = 0; k < 8; k++) send(32'hFFFF_FFFF, 1'b0, 1'b1);
        idle();
        check("full_valid", out_valid_a, 1);
        check("full_sum",   out_sum_a, 3968);
        check("full_count", out_count_a, 8);
        check("full_ovf",   out_ovf_a, 0);

        // Two-word frame closed by in_last
        send(32'h0000_0001, 1'b0, 1'b1);
        send(32'h8000_0000, 1'b1, 1'b1);
        idle();
        check("two_sum",   out_sum_a, 31);
        check("two_count", out_count_a, 2);

        // One-word frame held under back-pressure; next word must wait
        @(negedge clk);
        out_ready = 1'b0;
        send(32'h56AE_0FF0, 1'b1, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h0000_000F;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("hold_valid", out_valid_a, 1);
            check("hold_sum",   out_sum_a, 267);
            check("hold_count", out_count_a, 1);
            check("hold_ready", in_ready_a, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("hs_cycle_valid", out_valid_a, 0);
        check("hs_cycle_ready", in_ready_a, 1);
        @(negedge clk);
        idle();
        check("after_hs_valid", out_valid_a, 1);
        check("after_hs_sum",   out_sum_a, 6);
        check("after_hs_count", out_count_a, 1);

        // Saturation in the narrow instance, then a clean frame
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 9; k++) send(32'hFFFF_FFFF, (k == 8), 1'b0);
        idle();
        check("sat_valid", out_valid_b, 1);
        check("sat_sum",   out_sum_b, 4095);
        check("sat_ovf",   out_ovf_b, 1);
        check("sat_count", out_count_b, 9);
        @(negedge clk);
        send(32'h0000_0003, 1'b1, 1'b0);
        idle();
        check("post_sat_sum",   out_sum_b, 1);
        check("post_sat_ovf",   out_ovf_b, 0);
        check("post_sat_count", out_count_b, 1);

        // Reset mid-frame, overriding a simultaneous closing word
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 3; k++) send(32'hFFFF_FFFF, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        in_last  = 1'b1;
        do_reset();
        idle();
        for (int c = 0; c < 3; c++) begin
            check("discard_valid", out_valid_a, 0);
            @(negedge clk);
        end
        send(32'h0000_0000, 1'b1, 1'b1);
        idle();
        check("after_rst_valid", out_valid_a, 1);
        check("after_rst_sum",   out_sum_a, 0);
        check("after_rst_count", out_count_a, 1);

        // Back-to-back frames with in_valid held high
        @(negedge clk);
        do_reset();
        exp_sum = 0;
        b2b_mon = 1'b1;
        for (int k = 0; k < 24; k++) begin
            logic [31:0] w;
            w = (32'h0101_0101 * (k + 1)) ^ 32'h00F0_0F00;
            exp_sum += word_sum(w);
            send(w, 1'b0, 1'b1);
        end
        idle();
        repeat (3) @(negedge clk);
        b2b_mon = 1'b0;
        check("b2b_frames", hs_cnt, 3);
        check("b2b_words",  hs_words, 24);
        check("b2b_sum",    hs_sum, exp_sum);
        check("b2b_idle",   idle_cnt, 3);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
